// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480@60 Hz pipeline.
// Used by the timing generator and by downstream pixel sources.
package vga_pkg;

   localparam int unsigned CNT_W       = 10;
   localparam int unsigned COUNT_LIMIT = 1 << CNT_W;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   typedef logic [CNT_W-1:0] coord_t;

   function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                              int unsigned sync, int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; wrap is a same-cycle
// combinational pulse so it can chain into the next axis' increment.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned TOTAL = H_TOTAL_DEF
) (
   input  logic   clk_pix,
   input  logic   resetn,
   input  logic   inc,
   output coord_t count,
   output logic   wrap
);

   localparam coord_t Last = CNT_W'(TOTAL - 1);

   coord_t count_q, count_d;

   always_comb begin
      wrap    = inc && (count_q == Last);
      count_d = count_q;
      if (inc) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: chained h/v counters with a registered decode stage
// so every output describes the same pixel position.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned H_FP        = H_FP_DEF,
   parameter int unsigned H_SYNC      = H_SYNC_DEF,
   parameter int unsigned H_BP        = H_BP_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned V_FP        = V_FP_DEF,
   parameter int unsigned V_SYNC      = V_SYNC_DEF,
   parameter int unsigned V_BP        = V_BP_DEF,
   parameter bit          SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
   input  logic   clk_pix,
   input  logic   resetn,
   input  logic   pix_ce,
   output coord_t hcount,
   output coord_t vcount,
   output logic   de,
   output logic   hsync,
   output logic   vsync,
   output logic   line_start,
   output logic   frame_start
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > COUNT_LIMIT) begin : g_h_total_check
      $error("vga_timing: H_TOTAL does not fit in the 10-bit counter");
   end
   if (V_TOTAL > COUNT_LIMIT) begin : g_v_total_check
      $error("vga_timing: V_TOTAL does not fit in the 10-bit counter");
   end

   // One extra bit so a boundary equal to 1024 still compares correctly.
   localparam logic [CNT_W:0] HActEnd   = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] HSyncBeg  = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HSyncEnd  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] VActEnd   = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] VSyncBeg  = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VSyncEnd  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   coord_t h, v;
   logic   h_wrap;
   logic   unused_v_wrap;

   vga_axis_counter #(
      .TOTAL (H_TOTAL)
   ) u_h_counter (
      .clk_pix (clk_pix),
      .resetn  (resetn),
      .inc     (pix_ce),
      .count   (h),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(
      .TOTAL (V_TOTAL)
   ) u_v_counter (
      .clk_pix (clk_pix),
      .resetn  (resetn),
      .inc     (h_wrap),
      .count   (v),
      .wrap    (unused_v_wrap)
   );

   coord_t hcount_q, hcount_d, vcount_q, vcount_d;
   logic   de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic   h_in_sync, v_in_sync;

   always_comb begin
      h_in_sync = ({1'b0, h} >= HSyncBeg) && ({1'b0, h} < HSyncEnd);
      v_in_sync = ({1'b0, v} >= VSyncBeg) && ({1'b0, v} < VSyncEnd);

      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      de_d          = de_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      // Pulses only live for the clk_pix cycle that follows an enabled edge.
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_ce) begin
         hcount_d      = h;
         vcount_d      = v;
         de_d          = ({1'b0, h} < HActEnd) && ({1'b0, v} < VActEnd);
         hsync_d       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync_d       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         line_start_d  = (h == '0);
         frame_start_d = (h == '0) && (v == '0);
      end
   end

   always_ff @(posedge clk_pix) begin
      if (resetn) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         de_q          <= 1'b0;
         hsync_q       <= ~SYNC_ACTIVE;
         vsync_q       <= ~SYNC_ACTIVE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the 640x480@60 Hz raster: horizontal/vertical counters, sync pulses and data-enable on the pixel clock.
- Sits directly upstream of the pixel test-pattern generator and any later pixel sources, which consume hcount, vcount and de.
- hsync and vsync drive the VGA connector pins.
- All outputs are registered and mutually aligned, so a consumer's 1-cycle pixel stage sees consistent timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low, VGA standard)

Ports:
- clk_pix  in  1  pixel clock, ~25 MHz; the only clock
- resetn  in  1  synchronous, active-high reset (asserted = 1)
- pix_ce  in  1  pixel clock-enable; tie 1 at 25 MHz
- hcount  out  10  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- de  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
- hsync  out  1  horizontal sync, SYNC_ACTIVE when asserted
- vsync  out  1  vertical sync, SYNC_ACTIVE when asserted
- line_start  out  1  1-cycle pulse when hcount==0
- frame_start  out  1  1-cycle pulse when hcount==0 and vcount==0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
  - Both must fit in 10 bits; elaboration error otherwise.
- Internal counters h, v (10 bits each):
  - On a pix_ce=1 edge: h increments.
  - h==H_TOTAL-1 wraps to 0 and increments v.
  - v==V_TOTAL-1 with h wrap: v wraps to 0.
  - No other wrap points; counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Outputs are registered from decode of (h, v) on the same pix_ce edge, so every output reflects the same position.
  - Output latency from counter to pins: 1 cycle; hcount/vcount are the delayed copies.
- Decode, for hsync/vsync asserted:
  - hsync: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), asserted for whole lines.
- Reset: while resetn=1 at an edge, regardless of pix_ce:
  - h=0, v=0, hcount=0, vcount=0
  - de=0, hsync=vsync=!SYNC_ACTIVE
  - line_start=0, frame_start=0
- First pix_ce=1 edge after reset release:
  - Outputs hcount=0, vcount=0, de=1, line_start=1, frame_start=1; internal h becomes 1.
- pix_ce=0:
  - Counters and hcount/vcount/de/hsync/vsync hold.
  - line_start and frame_start forced 0, so each pulse lasts exactly one clk_pix cycle per pixel position.
- Reset mid-frame: output reset values on the next edge, then restart at (0,0) as above. No partial-frame recovery.
- Simultaneous h wrap and v wrap: both counters go to 0 on the same edge. The next output cycle is frame_start=1.

Decomposition:
- Shared package vga_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL computation, sync polarity constants. The pixel generator also uses these.
- One natural sub-module, vga_axis_counter, instantiated twice:
  - Ports: clk_pix, resetn, inc, TOTAL parameter.
  - Outputs: count, wrap.
  - The horizontal instance's wrap drives the vertical instance's inc.

Test Plan:
- Reset held 3 cycles, pix_ce=1 -> outputs hcount=0, vcount=0, de=0, hsync=vsync=1. First edge after release -> hcount=0, vcount=0, de=1, frame_start=1, line_start=1.
- Line 0, pix_ce=1 -> de=1 for hcount 0..639 and 0 for 640..799; hsync=0 exactly for hcount 656..751 (96 cycles); hcount 799 followed by hcount=0, vcount=1, line_start=1.
- Full frame -> line_start period 800 cycles; frame_start period 420000 cycles; vsync=0 exactly for vcount 490..491 (1600 cycles); de=0 for all vcount >= 480; vcount 524 wraps to 0.
- pix_ce alternating 1,0 -> frame_start period 840000 clk_pix cycles; line_start and frame_start high exactly one cycle each; all other outputs stable across pix_ce=0 cycles.
- resetn pulsed 1 cycle at hcount=300, vcount=200 -> next edge shows reset values; following edge shows hcount=0, vcount=0, frame_start=1.
- SYNC_ACTIVE=1 build -> hsync/vsync waveforms inverted versus the default; idle level 0 in reset; de and counts unchanged.
